exc_cp0_seq: RTL and testbench

Exception/ERET sequencer that acts as the initiator on the exception-side CP0 read/write port. It accepts one committed exception or ERET from the commit stage at a time. It performs the architectural CP0 read-modify-write sequence (Status, Cause, EPC, BadVAddr, EBase / ErrorEPC) one access per cycle, then issues a single-cycle pipeline flush with the redirect PC.

---
 rtl/exc_cp0_seq.sv | 161 ++++++++++++++++
 tb/tb_exc_cp0_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_cp0_seq.sv
// Exception/ERET sequencer: drives the CP0 read-modify-write sequence for one
// committed exception or ERET, then issues a single-cycle redirect.
module exc_cp0_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    output logic        exc_ready,
    input  logic        exc_is_eret,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_ds,
    input  logic [31:0] exc_badvaddr,
    output logic [4:0]  cp0_addr,
    output logic [2:0]  cp0_sel,
    output logic        cp0_writeEn,
    output logic [31:0] cp0_writeData,
    input  logic [31:0] cp0_readData,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [3:0] {
        IDLE, RD_STATUS, RD_CAUSE, RD_EBASE, RD_EPC,
        WR_EPC, WR_CAUSE, WR_BADV, WR_STATUS, REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic        eret_q, eret_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        ds_q, ds_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] st_q, st_d;
    logic [31:0] ca_q, ca_d;
    logic [31:0] tgt_q, tgt_d;
    logic        redir_vld_q, redir_vld_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        cause_bd;

    // A nested exception (EXL already set) keeps the original BD bit.
    assign cause_bd       = st_q[1] ? ca_q[31] : ds_q;
    assign exc_ready      = (state_q == IDLE);
    assign redirect_valid = redir_vld_q;
    assign redirect_pc    = redir_pc_q;

    always_comb begin
        state_d       = state_q;
        eret_d        = eret_q;
        code_d        = code_q;
        pc_d          = pc_q;
        ds_d          = ds_q;
        badv_d        = badv_q;
        st_d          = st_q;
        ca_d          = ca_q;
        tgt_d         = tgt_q;
        redir_vld_d   = 1'b0;
        redir_pc_d    = 32'h0;
        cp0_addr      = 5'd0;
        cp0_sel       = 3'd0;
        cp0_writeEn   = 1'b0;
        cp0_writeData = 32'h0;
        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    eret_d  = exc_is_eret;
                    code_d  = exc_code;
                    pc_d    = exc_pc;
                    ds_d    = exc_in_ds;
                    badv_d  = exc_badvaddr;
                    state_d = RD_STATUS;
                end
            end
            RD_STATUS: begin
                cp0_addr = 5'd12;
                st_d     = cp0_readData;
                state_d  = eret_q ? RD_EPC : RD_CAUSE;
            end
            RD_EPC: begin
                cp0_addr = st_q[2] ? 5'd30 : 5'd14;
                tgt_d    = cp0_readData;
                state_d  = WR_STATUS;
            end
            RD_CAUSE: begin
                cp0_addr = 5'd13;
                ca_d     = cp0_readData;
                state_d  = RD_EBASE;
            end
            RD_EBASE: begin
                cp0_addr = 5'd15;
                cp0_sel  = 3'd1;
                tgt_d    = st_q[22] ? 32'hBFC0_0380 : {cp0_readData[31:12], 12'h180};
                state_d  = st_q[1] ? WR_CAUSE : WR_EPC;
            end
            WR_EPC: begin
                cp0_addr      = 5'd14;
                cp0_writeEn   = 1'b1;
                cp0_writeData = ds_q ? (pc_q - 32'd4) : pc_q;
                state_d       = WR_CAUSE;
            end
            WR_CAUSE: begin
                cp0_addr      = 5'd13;
                cp0_writeEn   = 1'b1;
                cp0_writeData = {cause_bd, ca_q[30:7], code_q, ca_q[1:0]};
                state_d       = (code_q == 5'd4 || code_q == 5'd5) ? WR_BADV : WR_STATUS;
            end
            WR_BADV: begin
                cp0_addr      = 5'd8;
                cp0_writeEn   = 1'b1;
                cp0_writeData = badv_q;
                state_d       = WR_STATUS;
            end
            WR_STATUS: begin
                cp0_addr    = 5'd12;
                cp0_writeEn = 1'b1;
                if (!eret_q)
                    cp0_writeData = st_q | 32'h2;
                else if (st_q[2])
                    cp0_writeData = st_q & ~32'h4;
                else
                    cp0_writeData = st_q & ~32'h2;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                // Pulse is registered so it lands together with exc_ready.
                redir_vld_d = 1'b1;
                redir_pc_d  = tgt_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            eret_q      <= 1'b0;
            code_q      <= 5'd0;
            pc_q        <= 32'h0;
            ds_q        <= 1'b0;
            badv_q      <= 32'h0;
            st_q        <= 32'h0;
            ca_q        <= 32'h0;
            tgt_q       <= 32'h0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            eret_q      <= eret_d;
            code_q      <= code_d;
            pc_q        <= pc_d;
            ds_q        <= ds_d;
            badv_q      <= badv_d;
            st_q        <= st_d;
            ca_q        <= ca_d;
            tgt_q       <= tgt_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

endmodule

// File: tb/tb_exc_cp0_seq.sv
// Bench for exc_cp0_seq: CP0 register array stand-in plus a per-request
// reference model of the architectural effect, latency and redirect target.
module tb_exc_cp0_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, exc_ready, exc_is_eret, exc_in_ds;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic        cp0_writeEn;
    logic [31:0] cp0_writeData, cp0_readData;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] mem [0:255];
    assign cp0_readData = mem[{cp0_addr, cp0_sel}];

    exc_cp0_seq dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_is_eret(exc_is_eret),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_in_ds(exc_in_ds),
        .exc_badvaddr(exc_badvaddr),
        .cp0_addr(cp0_addr), .cp0_sel(cp0_sel), .cp0_writeEn(cp0_writeEn),
        .cp0_writeData(cp0_writeData), .cp0_readData(cp0_readData),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        eret;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
    } req_t;

    localparam logic [7:0] I_BADV = 8'd64, I_ST = 8'd96, I_CA = 8'd104,
                           I_EPC = 8'd112, I_EBASE = 8'd121, I_EEPC = 8'd240;

    int total = 0, bad = 0;
    req_t q_req[$];
    logic [31:0] m_st, m_ca, m_epc, m_eepc, m_badv, m_ebase;
    int e_n, e_nw, last_n;
    logic [31:0] e_pc, last_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] st, ca, epc, eepc, badv, ebase);
        m_st = st; m_ca = ca; m_epc = epc; m_eepc = eepc; m_badv = badv; m_ebase = ebase;
        mem[I_ST] = st; mem[I_CA] = ca; mem[I_EPC] = epc;
        mem[I_EEPC] = eepc; mem[I_BADV] = badv; mem[I_EBASE] = ebase;
    endtask

    // Architectural effect of one request: reads + writes + one redirect cycle.
    task automatic ref_apply(input req_t r);
        int nrd, nwr;
        logic [31:0] st;
        st = m_st;
        if (r.eret) begin
            e_pc = st[2] ? m_eepc : m_epc;
            m_st = st[2] ? (st & ~32'h4) : (st & ~32'h2);
            nrd = 2; nwr = 1;
        end else begin
            e_pc = st[22] ? 32'hBFC00380 : {m_ebase[31:12], 12'h180};
            nrd = 3; nwr = 2;
            if (!st[1]) begin
                m_epc = r.ds ? r.pc - 32'd4 : r.pc;
                nwr++;
            end
            m_ca = {(st[1] ? m_ca[31] : r.ds), m_ca[30:7], r.code, m_ca[1:0]};
            if (r.code == 5'd4 || r.code == 5'd5) begin
                m_badv = r.badv;
                nwr++;
            end
            m_st = st | 32'h2;
        end
        e_n = nrd + nwr + 1;
        e_nw = nwr;
    endtask

    task automatic run_all();
        int guard = 0, cyc = 0, acc_cyc = 0, redir_cyc = -1, wcnt = 0, outstanding = 0;
        bit acc;
        req_t r;
        while ((q_req.size() > 0 || outstanding > 0) && guard < 400) begin
            if (q_req.size() > 0) begin
                r = q_req[0];
                exc_valid = 1'b1; exc_is_eret = r.eret; exc_code = r.code;
                exc_pc = r.pc; exc_in_ds = r.ds; exc_badvaddr = r.badv;
            end else begin
                exc_valid = 1'b0;
            end
            acc = exc_valid && exc_ready;
            @(posedge clk);
            cyc++;
            if (acc) begin
                r = q_req.pop_front();
                ref_apply(r);
                if (redir_cyc >= 0) chk("b2b_accept_edge", 32'(cyc), 32'(redir_cyc + 1));
                acc_cyc = cyc;
                outstanding++;
                wcnt = 0;
            end
            @(negedge clk);
            if (cp0_writeEn) begin
                mem[{cp0_addr, cp0_sel}] = cp0_writeData;
                wcnt++;
            end
            if (outstanding > 0) chk("ready_busy", 32'(exc_ready), 32'(redirect_valid));
            if (redirect_valid) begin
                last_n = cyc - acc_cyc;
                last_pc = redirect_pc;
                chk("latency", 32'(last_n), 32'(e_n));
                chk("redir_pc", redirect_pc, e_pc);
                chk("nwrites", 32'(wcnt), 32'(e_nw));
                chk("status", mem[I_ST], m_st);
                chk("cause", mem[I_CA], m_ca);
                chk("epc", mem[I_EPC], m_epc);
                chk("badv", mem[I_BADV], m_badv);
                redir_cyc = cyc;
                outstanding--;
            end
            guard++;
        end
        exc_valid = 1'b0;
        if (guard >= 400) begin
            chk("timeout", 32'd1, 32'd0);
            q_req.delete();
        end
    endtask

    function automatic req_t mk(input logic eret, input logic [4:0] code,
                                input logic [31:0] pc, input logic ds, input logic [31:0] badv);
        req_t r;
        r.eret = eret; r.code = code; r.pc = pc; r.ds = ds; r.badv = badv;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b0;
        exc_valid = 1'b0; exc_is_eret = 1'b0; exc_code = 5'd0;
        exc_pc = 32'h0; exc_in_ds = 1'b0; exc_badvaddr = 32'h0;
        #3;
        chk("rst_ready", 32'(exc_ready), 32'd1);
        chk("rst_redir", 32'(redirect_valid), 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'h0);
        chk("rst_wen", 32'(cp0_writeEn), 32'd0);
        chk("rst_wdata", cp0_writeData, 32'h0);
        chk("rst_addr", {24'h0, cp0_addr, cp0_sel}, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // BEV vector, plain exception
        preload(32'h00400000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000);
        q_req.push_back(mk(1'b0, 5'd8, 32'h80001000, 1'b0, 32'h0));
        run_all();
        chk("t1_epc", mem[I_EPC], 32'h80001000);
        chk("t1_cause", mem[I_CA], 32'h00000020);
        chk("t1_status", mem[I_ST], 32'h00400002);
        chk("t1_pc", last_pc, 32'hBFC00380);
        chk("t1_n", 32'(last_n), 32'd7);

        // delay-slot AdEL
        preload(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000);
        q_req.push_back(mk(1'b0, 5'd4, 32'h80002004, 1'b1, 32'h00000003));
        run_all();
        chk("t2_epc", mem[I_EPC], 32'h80002000);
        chk("t2_cause", mem[I_CA], 32'h80000010);
        chk("t2_badv", mem[I_BADV], 32'h00000003);
        chk("t2_pc", last_pc, 32'h80000180);
        chk("t2_n", 32'(last_n), 32'd8);

        // nested exception keeps EPC and BD
        preload(32'h00000002, 32'h80000000, 32'h12345678, 32'h0, 32'h0, 32'h9000A000);
        q_req.push_back(mk(1'b0, 5'd10, 32'h80003000, 1'b0, 32'h0));
        run_all();
        chk("t3_epc", mem[I_EPC], 32'h12345678);
        chk("t3_cause", mem[I_CA], 32'h80000028);
        chk("t3_n", 32'(last_n), 32'd6);

        // ERET from EXL
        preload(32'h00000002, 32'h0, 32'h8000ABC0, 32'h11111110, 32'h0, 32'h80000000);
        q_req.push_back(mk(1'b1, 5'd0, 32'h0, 1'b0, 32'h0));
        run_all();
        chk("t4_status", mem[I_ST], 32'h0);
        chk("t4_pc", last_pc, 32'h8000ABC0);
        chk("t4_n", 32'(last_n), 32'd4);

        // ERET from ERL, followed back-to-back by an exception held while busy
        preload(32'h00000004, 32'h0, 32'h8000ABC0, 32'hBFC00000, 32'h0, 32'h80000000);
        q_req.push_back(mk(1'b1, 5'd0, 32'h0, 1'b0, 32'h0));
        q_req.push_back(mk(1'b0, 5'd12, 32'h80004000, 1'b0, 32'h0));
        run_all();
        chk("t5_pc", last_pc, 32'h80000180);

        // reset asserted while Cause is being written
        preload(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000);
        exc_valid = 1'b1; exc_is_eret = 1'b0; exc_code = 5'd8;
        exc_pc = 32'h80005000; exc_in_ds = 1'b0;
        @(posedge clk); @(negedge clk);
        exc_valid = 1'b0;
        begin
            int k = 0;
            while (!(cp0_writeEn && cp0_addr == 5'd13) && k < 20) begin
                @(posedge clk); @(negedge clk);
                k++;
            end
            chk("rst_reach_wr_cause", 32'(k < 20), 32'd1);
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_wen", 32'(cp0_writeEn), 32'd0);
        chk("mid_rst_ready", 32'(exc_ready), 32'd1);
        chk("mid_rst_redir", 32'(redirect_valid), 32'd0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_redir", 32'(redirect_valid), 32'd0);
            chk("post_rst_wen", 32'(cp0_writeEn), 32'd0);
        end

        // randomized batches, each request held until accepted
        for (int b = 0; b < 8; b++) begin
            preload({$urandom} & 32'hFFFF_FFF9 | (32'($urandom_range(0, 1)) << 1)
                        | (32'($urandom_range(0, 1)) << 2),
                    $urandom, $urandom, $urandom, $urandom, $urandom);
            for (int j = 0; j < 3; j++) begin
                req_t r;
                r.eret = ($urandom_range(0, 3) == 0);
                r.code = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5))
                                                     : 5'($urandom_range(0, 31));
                r.pc   = $urandom;
                r.ds   = 1'($urandom_range(0, 1));
                r.badv = $urandom;
                q_req.push_back(r);
            end
            run_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
